// File: rtl/shift_register_4b.sv
// Serial-in / parallel-in, parallel-out shift register with a serial-out tap.
// Each rising edge either resets, parallel-loads d, or shifts left with si entering at bit 0.
module shift_register_4b #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shifted;

    // Left-shifted view of the current contents; si fills the vacated LSB.
    assign shifted[0] = si;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shifted[gi] = shift_q[gi-1];
        end
    endgenerate

    always_comb begin
        shift_d = shifted;
        if (load) begin
            shift_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= RESET_VALUE;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q  = shift_q;
    assign so = shift_q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_4b.sv
// Directed bench for shift_register_4b: reset priority, load, shift, flush and mid-operation reset/load.
module tb_shift_register_4b;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] d;
    logic       si;
    logic [3:0] q;
    logic       so;

    int errors = 0;
    int checks = 0;

    shift_register_4b #(
        .WIDTH       (4),
        .RESET_VALUE (4'b0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .d     (d),
        .si    (si),
        .q     (q),
        .so    (so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_q(input string tag, input logic [3:0] exp);
        checks++;
        assert (q === exp) else begin
            errors++;
            $error("FAIL %s: q got %b expected %b", tag, q, exp);
        end
        $display("check %s: q=%b (expected %b)", tag, q, exp);
    endtask

    task automatic check_so(input string tag, input logic exp);
        checks++;
        assert (so === exp) else begin
            errors++;
            $error("FAIL %s: so got %b expected %b", tag, so, exp);
        end
        $display("check %s: so=%b (expected %b)", tag, so, exp);
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        d     = 4'b0000;
        si    = 1'b0;
        #2;

        // Reset wins over load
        reset = 1'b0; load = 1'b1; d = 4'b1111; si = 1'b1;
        step();
        check_q("reset_q", 4'b0000);
        check_so("reset_so", 1'b0);

        // Parallel load
        reset = 1'b1; load = 1'b1; d = 4'b1001; si = 1'b0;
        step();
        check_q("load_q", 4'b1001);
        check_so("load_so", 1'b1);

        // Shift sequence
        load = 1'b0; si = 1'b1;
        step();
        check_q("shift1_q", 4'b0011);
        check_so("shift1_so", 1'b0);
        si = 1'b1;
        step();
        check_q("shift2_q", 4'b0111);
        check_so("shift2_so", 1'b0);
        si = 1'b0;
        step();
        check_q("shift3_q", 4'b1110);
        check_so("shift3_so", 1'b1);
        si = 1'b1;
        step();
        check_q("shift4_q", 4'b1101);
        check_so("shift4_so", 1'b1);

        // Reset mid-shift, then resume shifting
        reset = 1'b0; si = 1'b1;
        step();
        check_q("midreset_q", 4'b0000);
        reset = 1'b1; load = 1'b0; si = 1'b1;
        step();
        check_q("resume_q", 4'b0001);

        // Full flush of 1010: so before each edge is 1,0,1,0
        load = 1'b1; d = 4'b1010;
        step();
        check_q("flush_load_q", 4'b1010);
        load = 1'b0; si = 1'b0;
        check_so("flush_so0", 1'b1);
        step();
        check_q("flush1_q", 4'b0100);
        check_so("flush_so1", 1'b0);
        step();
        check_q("flush2_q", 4'b1000);
        check_so("flush_so2", 1'b1);
        step();
        check_q("flush3_q", 4'b0000);
        check_so("flush_so3", 1'b0);
        step();
        check_q("flush4_q", 4'b0000);

        // Build 0111, then load during shifting
        si = 1'b1;
        step();
        step();
        step();
        check_q("build_q", 4'b0111);
        load = 1'b1; d = 4'b0100; si = 1'b1;
        step();
        check_q("load_mid_q", 4'b0100);
        load = 1'b0; si = 1'b0;
        step();
        check_q("after_load_q", 4'b1000);

        // Consecutive loads; d changes before the edge, last value captured
        load = 1'b1; d = 4'b0110; si = 1'b1;
        step();
        check_q("cons_load1_q", 4'b0110);
        d = 4'b1111;
        #3;
        d = 4'b1011;
        step();
        check_q("cons_load2_q", 4'b1011);
        check_so("cons_load2_so", 1'b1);

        // Non-zero serial fill after flush: last 4 si values, oldest in MSB
        load = 1'b0;
        si = 1'b1; step();
        si = 1'b0; step();
        si = 1'b0; step();
        si = 1'b1; step();
        check_q("fill_q", 4'b1001);
        check_so("fill_so", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_register_4b.md
Name: shift_register_4b

Overview:
- Parameterised serial-in / parallel-in, parallel-out shift register, 4 bits by default.
- Every clock it does one of three things: reset to a constant, parallel-load a word, or shift left by one with a serial bit entering at the LSB.
- Used as a generic datapath/serialisation primitive; registered parallel output plus a serial-out tap.

Parameters:
- WIDTH, 4, register width in bits; legal range >= 2.
- RESET_VALUE, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk    input   1      rising-edge clock; sole clock domain.
- reset  input   1      synchronous, active-low reset; sampled on rising clk edge.
- load   input   1      parallel load request; active-high.
- d      input   WIDTH  parallel load data.
- si     input   1      serial input bit; enters at q[0] on shift.
- q      output  WIDTH  register contents; driven directly from flops.
- so     output  1      serial output; combinational copy of q[WIDTH-1], the bit lost on the next shift.

Behaviour:
- One clock (clk) only; reset is synchronous and active-low. No asynchronous paths; all state changes on the rising edge of clk.
- Priority per rising edge: reset low > load high > shift.
- Reset (reset==0): q <= RESET_VALUE. load, d and si are ignored that cycle.
- Load (reset==1, load==1): q <= d. si is ignored; the old contents are discarded.
- Shift (reset==1, load==0): q <= {q[WIDTH-2:0], si}.
  - No shift-enable: the register shifts every cycle it is neither reset nor loading.
  - The old q[WIDTH-1] is discarded; it was visible on so before the edge.
- Latency: one cycle. Values are visible on q right after the edge that captured them.
- so always equals q[WIDTH-1]. It is a combinational alias with no extra register stage.
- Power-up, before the first reset edge: q is unspecified (X in simulation). Benches must reset before checking.
- Reset mid-operation: an in-progress shift sequence is abandoned and q returns to RESET_VALUE on that edge. Shifting resumes on the first edge with reset==1 and load==0.
- Load asserted on consecutive cycles: each edge reloads d; no shifting happens in between.
- Load while d changes: only the value present at the clock edge is captured.
- Inputs are treated as synchronous to clk. No internal synchronisers.
- Width rules:
  - After exactly WIDTH shifts, all loaded data has left via so.
  - q then holds the last WIDTH si values, oldest in the MSB.
- No X-propagation masking: an X on si, or on d during load, appears in q.

Test Plan:
- Reset: hold reset=0 for 1 edge with load=1, d=1111, si=1 -> q=0000, so=0 (reset wins over load).
- Parallel load: reset=1, load=1, d=1001 for 1 edge -> q=1001, so=1.
- Shift sequence after loading 1001, load=0:
  - si=1 -> q=0011
  - si=1 -> q=0111
  - si=0 -> q=1110
  - si=1 -> q=1101
  - check so=q[3] after each edge.
- Full flush: load 1010, then 4 edges with si=0 -> q=0000. so sequence seen before each edge is 1,0,1,0.
- Load during shifting: mid-shift with q=0111, assert load=1, d=0100, si=1 -> q=0100 (no shift applied). Next edge with load=0, si=0 -> q=1000.
- Reset mid-shift: with q=1101, drive reset=0 for one edge -> q=0000. Release reset with si=1 -> q=0001 on the next edge.
